nmi_rr_arbiter: RTL and testbench
=================================

# nmi_rr_arbiter

- Shares one downstream NMI slave port among `NUM_MST` NMI masters, e.g. the CPU data port and the DMA master feeding the native peripheral decoder.
- Arbitration is round-robin: one outstanding transaction at a time, grant held until the slave responds.
- A bus-timeout watchdog completes hung transactions with an error pattern, so no master can stall the fabric.

## Interface
Parameters:
- `NUM_MST`, 2, number of requesting masters (2..8).
- `TIMEOUT_CYC`, 1023, maximum BUSY cycles without `s_ready_i` before forced completion; 0 disables the watchdog.
- `ERR_RDATA`, 32'hDEAD_BEEF, read data returned on timeout.

Ports (one clock; reset is synchronous and active-low):
- `clk_i` in 1: system clock.
- `rst_n_i` in 1: synchronous active-low reset.
- `m_valid_i` in [NUM_MST]: master request valid.
- `m_addr_i` in [NUM_MST][32]: master address.
- `m_wdata_i` in [NUM_MST][32]: master write data.
- `m_wstrb_i` in [NUM_MST][4]: byte strobes; 0 means read.
- `m_ready_o` out [NUM_MST]: per-master completion strobe.
- `m_rdata_o` out [NUM_MST][32]: per-master read data, valid with `m_ready_o`.
- `s_valid_o` out 1: slave request valid.
- `s_addr_o`, `s_wdata_o` out 32: forwarded from the granted master.
- `s_wstrb_o` out 4: forwarded from the granted master.
- `s_ready_i` in 1: slave completion.
- `s_rdata_i` in 32: slave read data.
- `grant_o` out [NUM_MST]: one-hot current owner (debug); 0 when idle.
- `timeout_o` out 1: one-cycle pulse on a forced completion.

## Operation
FSM states are IDLE and BUSY.

IDLE:
- If any `m_valid_i` is set, pick the first set bit at or after `rr_ptr` (cyclic).
- Register the winner as `gnt_idx`, clear the timeout counter, go to BUSY.
- If no request is present, stay in IDLE.

BUSY:
- `s_valid_o = m_valid_i[gnt_idx]`; addr/wdata/wstrb are muxed combinationally from `gnt_idx`.
- If `s_ready_i`:
  - `m_ready_o[gnt_idx]=1` and `m_rdata_o[gnt_idx]=s_rdata_i` in the same cycle.
  - `rr_ptr <= (gnt_idx+1) mod NUM_MST`; go to IDLE.
- Else if `TIMEOUT_CYC!=0` and `cnt==TIMEOUT_CYC`:
  - `s_valid_o` is forced 0 that cycle; `m_ready_o[gnt_idx]=1`; `m_rdata_o[gnt_idx]=ERR_RDATA`; `timeout_o=1`.
  - Pointer advances as on normal completion; go to IDLE.
- Else `cnt<=cnt+1`, saturating at `TIMEOUT_CYC`.

General rules:
- Non-granted masters see `m_ready_o=0` and `m_rdata_o=0`.
- Masters must hold valid and payload stable until ready (NMI rule). If `m_valid_i[gnt_idx]` drops mid-BUSY, `s_valid_o` follows it low; the FSM stays in BUSY and the watchdog still runs.
- An abandoned slave after timeout is not reset by this block.
- Counter width is `$clog2(TIMEOUT_CYC+1)`, minimum 1.

## Timing
- Reset values: state IDLE, `rr_ptr=0`, `cnt=0`, `gnt_idx=0`. All outputs are 0 (`s_valid_o`, `m_ready_o`, `m_rdata_o`, `grant_o`, `timeout_o`).
- Reset asserted mid-BUSY: the next edge returns to IDLE and `s_valid_o` drops. The pending master never sees ready.
- Arbitration latency: a request sampled in IDLE at cycle N gives `s_valid_o` at cycle N+1.
- With a zero-wait slave, `m_ready_o` fires at N+1, the FSM is in IDLE at N+2, and the next grant is in BUSY at N+3. Peak throughput is one transaction per 2 cycles.
- `m_ready_o`/`m_rdata_o` are combinational from `s_ready_i`/`s_rdata_i`; there is no added response latency.
- Timeout completes on BUSY cycle `TIMEOUT_CYC+1`, counting the first BUSY cycle as 1.
- Simultaneous `s_ready_i` and timeout in the same cycle: `s_ready_i` wins and no `timeout_o` is issued.
- Requests arriving in a completion cycle are not granted until the following IDLE cycle.

## Structure
- Package `nmi_arb_pkg`: state enum `nmi_arb_state_e {ARB_IDLE, ARB_BUSY}` and default constant `NMI_ARB_ERR_RDATA`.
- Sub-module `nmi_rr_pick` (combinational): inputs req[NUM_MST] and ptr; outputs a one-hot winner, its index, and an any flag. Implementation is a double-width mask-and-priority encode.
- The top level holds the FSM, `rr_ptr`, `gnt_idx`, the timeout counter and the payload muxes.

## Test plan
- **Single read, zero-wait slave.** Master 0 reads 0x1000_1000 with `s_ready_i` tied 1 and `s_rdata_i=0x1234_5678` → `s_valid_o` high exactly 1 cycle, one cycle after the request; `m_rdata_o[0]=0x1234_5678` with `m_ready_o[0]`.
- **Fairness under contention.** Both masters hold continuous requests, slave has 2 wait states → grants alternate 0,1,0,1 over 8 transactions; no master is granted twice in a row.
- **Write forwarding.** Master 1 writes 0xA5A5_A5A5 with wstrb 4'b0011 to 0x1000_2004 → the slave sees exactly these values for the whole BUSY phase; the master 0 ready/rdata stay 0.
- **Timeout.** `TIMEOUT_CYC=8`, slave never ready → on BUSY cycle 9, `m_ready_o[0]=1`, `m_rdata_o[0]=0xDEAD_BEEF`, `timeout_o` pulses once, `s_valid_o=0`. A following master 1 request completes normally.
- **Ready/timeout race.** `s_ready_i` asserted exactly on BUSY cycle 9 with `TIMEOUT_CYC=8` → slave data is returned and `timeout_o` stays 0.
- **Reset mid-transaction.** `rst_n_i` low for 1 cycle during BUSY → all outputs are 0 the next cycle. After release, a master 1 request is granted first because `rr_ptr` is reset to 0 and master 0 is idle.

Source files
------------

// File: rtl/nmi_arb_pkg.sv
// -----------------------------------------------------------------------------
// nmi_arb_pkg
// Shared types and constants for the NMI round-robin arbiter.
//   nmi_arb_state_e   : arbiter FSM states (idle / transaction in flight)
//   NMI_ARB_ERR_RDATA : default read data returned on a watchdog completion
//   nmi_arb_cnt_w()   : width of the watchdog counter for a given timeout
// -----------------------------------------------------------------------------
package nmi_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } nmi_arb_state_e;

  localparam logic [31:0] NMI_ARB_ERR_RDATA = 32'hDEAD_BEEF;

  // The counter must hold TIMEOUT_CYC itself; a disabled watchdog still
  // needs a 1-bit vector so the declarations stay legal.
  function automatic int unsigned nmi_arb_cnt_w(input int unsigned timeout_cyc);
    if (timeout_cyc == 0) begin
      return 1;
    end
    return $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/nmi_rr_pick.sv
// -----------------------------------------------------------------------------
// nmi_rr_pick
// Combinational round-robin picker: returns the first set request bit at or
// after ptr_i, wrapping cyclically.
//   req_i     : request vector, one bit per master
//   ptr_i     : index with highest priority this round
//   win_oh_o  : one-hot winner (all zero when no request)
//   win_idx_o : binary index of the winner (0 when no request)
//   any_o     : at least one request present
// -----------------------------------------------------------------------------
module nmi_rr_pick #(
  parameter  int unsigned NUM_MST = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_MST)
) (
  input  logic [NUM_MST-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_MST-1:0] win_oh_o,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               any_o
);

  logic [2*NUM_MST-1:0] req_dbl;
  logic [2*NUM_MST-1:0] req_masked;
  logic                 found;

  // The request vector is duplicated so that masking off everything below
  // ptr_i leaves the wrapped-around requests in the upper copy; the lowest
  // surviving bit is then the cyclic winner.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // otherwise paths that skip the assignment infer a latch.
    win_oh_o   = '0;
    win_idx_o  = '0;
    found      = 1'b0;
    req_dbl    = {req_i, req_i};
    req_masked = req_dbl & ({(2*NUM_MST){1'b1}} << ptr_i);
    any_o      = |req_i;
    for (int i = 0; i < 2 * NUM_MST; i++) begin
      if (!found && req_masked[i]) begin
        found     = 1'b1;
        win_idx_o = IDX_W'(i % int'(NUM_MST));
      end
    end
    if (any_o) begin
      win_oh_o[win_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/nmi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// nmi_rr_arbiter
// Shares one NMI slave port among NUM_MST NMI masters with round-robin
// arbitration, one outstanding transaction at a time. A watchdog completes a
// transaction with ERR_RDATA after TIMEOUT_CYC+1 BUSY cycles without
// s_ready_i (TIMEOUT_CYC = 0 disables it).
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   m_valid_i/addr/wdata/wstrb : per-master request (wstrb 0 = read)
//   m_ready_o, m_rdata_o    : per-master completion strobe and read data
//   s_valid_o/addr/wdata/wstrb : request forwarded from the granted master
//   s_ready_i, s_rdata_i    : slave completion and read data
//   grant_o                 : one-hot owner while BUSY, 0 when idle
//   timeout_o               : one-cycle pulse on a forced completion
// -----------------------------------------------------------------------------
module nmi_rr_arbiter
  import nmi_arb_pkg::*;
#(
  parameter int unsigned NUM_MST     = 2,
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter logic [31:0] ERR_RDATA   = NMI_ARB_ERR_RDATA
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_MST-1:0]       m_valid_i,
  input  logic [NUM_MST-1:0][31:0] m_addr_i,
  input  logic [NUM_MST-1:0][31:0] m_wdata_i,
  input  logic [NUM_MST-1:0][3:0]  m_wstrb_i,
  output logic [NUM_MST-1:0]       m_ready_o,
  output logic [NUM_MST-1:0][31:0] m_rdata_o,
  output logic                     s_valid_o,
  output logic [31:0]              s_addr_o,
  output logic [31:0]              s_wdata_o,
  output logic [3:0]               s_wstrb_o,
  input  logic                     s_ready_i,
  input  logic [31:0]              s_rdata_i,
  output logic [NUM_MST-1:0]       grant_o,
  output logic                     timeout_o
);

  localparam int unsigned      IDX_W    = $clog2(NUM_MST);
  localparam int unsigned      CNT_W    = nmi_arb_cnt_w(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic             WDOG_EN  = (TIMEOUT_CYC != 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MST - 1);

  nmi_arb_state_e     state_q,   state_d;
  logic [IDX_W-1:0]   rr_ptr_q,  rr_ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [NUM_MST-1:0] gnt_oh_q,  gnt_oh_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;

  logic [NUM_MST-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic busy;
  logic timeout_hit;
  logic done;

  nmi_rr_pick #(
    .NUM_MST (NUM_MST)
  ) u_pick (
    .req_i     (m_valid_i),
    .ptr_i     (rr_ptr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  // Slave-side and master-side outputs. Responses are combinational from the
  // slave so completion adds no cycle of latency.
  always_comb begin
    busy        = (state_q == ARB_BUSY);
    // s_ready_i has priority: a ready arriving on the timeout cycle is a
    // normal completion.
    timeout_hit = busy && WDOG_EN && !s_ready_i && (cnt_q == CNT_MAX);
    done        = busy && (s_ready_i || timeout_hit);

    s_valid_o = busy && m_valid_i[gnt_idx_q] && !timeout_hit;
    s_addr_o  = busy ? m_addr_i[gnt_idx_q]  : '0;
    s_wdata_o = busy ? m_wdata_i[gnt_idx_q] : '0;
    s_wstrb_o = busy ? m_wstrb_i[gnt_idx_q] : '0;

    grant_o   = busy ? gnt_oh_q : '0;
    m_ready_o = done ? gnt_oh_q : '0;
    m_rdata_o = '0;
    if (done) begin
      m_rdata_o[gnt_idx_q] = s_ready_i ? s_rdata_i : ERR_RDATA;
    end
    timeout_o = timeout_hit;
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_oh_d  = gnt_oh_q;
    cnt_d     = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d   = ARB_BUSY;
          gnt_idx_d = pick_idx;
          gnt_oh_d  = pick_oh;
          cnt_d     = '0;
        end
      end
      ARB_BUSY: begin
        if (done) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + IDX_W'(1);
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments make every flop update from pre-edge
    // values, independent of statement order.
    if (!rst_n_i) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_oh_q  <= gnt_oh_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_nmi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nmi_rr_arbiter
// Self-checking bench for nmi_rr_arbiter (3 masters, TIMEOUT_CYC = 8).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_nmi_rr_arbiter;

  localparam int          N   = 3;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic               clk;
  logic               rst_n_i;
  logic [N-1:0]       m_valid_i;
  logic [N-1:0][31:0] m_addr_i;
  logic [N-1:0][31:0] m_wdata_i;
  logic [N-1:0][3:0]  m_wstrb_i;
  logic [N-1:0]       m_ready_o;
  logic [N-1:0][31:0] m_rdata_o;
  logic               s_valid_o;
  logic [31:0]        s_addr_o;
  logic [31:0]        s_wdata_o;
  logic [3:0]         s_wstrb_o;
  logic               s_ready_i;
  logic [31:0]        s_rdata_i;
  logic [N-1:0]       grant_o;
  logic               timeout_o;

  int errors = 0;
  int checks = 0;

  nmi_rr_arbiter #(
    .NUM_MST     (N),
    .TIMEOUT_CYC (TO),
    .ERR_RDATA   (ERR)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n_i),
    .m_valid_i (m_valid_i),
    .m_addr_i  (m_addr_i),
    .m_wdata_i (m_wdata_i),
    .m_wstrb_i (m_wstrb_i),
    .m_ready_o (m_ready_o),
    .m_rdata_o (m_rdata_o),
    .s_valid_o (s_valid_o),
    .s_addr_o  (s_addr_o),
    .s_wdata_o (s_wdata_o),
    .s_wstrb_o (s_wstrb_o),
    .s_ready_i (s_ready_i),
    .s_rdata_i (s_rdata_i),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_valid_i = '0;
    m_addr_i  = '0;
    m_wdata_i = '0;
    m_wstrb_i = '0;
    s_ready_i = 1'b0;
    s_rdata_i = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n_i = 1'b0;
    step();
    step();
    rst_n_i = 1'b1;
  endtask

  task automatic request(input int m, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
    m_valid_i[m] = 1'b1;
    m_addr_i[m]  = a;
    m_wdata_i[m] = wd;
    m_wstrb_i[m] = ws;
  endtask

  // ---------------- reference model ----------------
  // Cyclic search for the first requester starting at ptr.
  function automatic int model_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    rst_n_i   = 1'b0;
    m_valid_i = '1;
    s_ready_i = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if (s_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_s_valid: got %b want 0", s_valid_o);
    end
    checks++;
    if (m_ready_o !== '0) begin
      errors++; $display("FAIL reset_m_ready: got %b want 0", m_ready_o);
    end
    checks++;
    if (m_rdata_o !== '0) begin
      errors++; $display("FAIL reset_m_rdata: got %h want 0", m_rdata_o);
    end
    checks++;
    if (grant_o !== '0) begin
      errors++; $display("FAIL reset_grant: got %b want 0", grant_o);
    end
    checks++;
    if (timeout_o !== 1'b0) begin
      errors++; $display("FAIL reset_timeout: got %b want 0", timeout_o);
    end
    clear_inputs();
    rst_n_i = 1'b1;
  endtask

  task automatic test_single_read();
    apply_reset();
    s_ready_i = 1'b1;
    s_rdata_i = 32'h1234_5678;
    request(0, 32'h1000_1000, 32'h0, 4'b0000);
    @(negedge clk);
    checks++;
    if (s_valid_o !== 1'b0) begin
      errors++; $display("FAIL single_req_cycle_s_valid: got %b want 0", s_valid_o);
    end
    step();
    @(negedge clk);
    checks++;
    if ({s_valid_o, s_addr_o, s_wstrb_o} !== {1'b1, 32'h1000_1000, 4'b0000}) begin
      errors++; $display("FAIL single_slave_req: got v=%b a=%h s=%b want v=1 a=10001000 s=0000",
                         s_valid_o, s_addr_o, s_wstrb_o);
    end
    checks++;
    if ({m_ready_o, m_rdata_o[0], grant_o} !== {3'b001, 32'h1234_5678, 3'b001}) begin
      errors++; $display("FAIL single_resp: got rdy=%b rd=%h gnt=%b want rdy=001 rd=12345678 gnt=001",
                         m_ready_o, m_rdata_o[0], grant_o);
    end
    step();
    m_valid_i[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({s_valid_o, m_ready_o} !== 4'b0000) begin
        errors++; $display("FAIL single_after_%0d: got v=%b rdy=%b want v=0 rdy=000",
                           c, s_valid_o, m_ready_o);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_write_forwarding();
    apply_reset();
    request(1, 32'h1000_2004, 32'hA5A5_A5A5, 4'b0011);
    step();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        s_ready_i = 1'b1;
        s_rdata_i = 32'h0BAD_F00D;
      end
      @(negedge clk);
      checks++;
      if ({s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o} !==
          {1'b1, 32'h1000_2004, 32'hA5A5_A5A5, 4'b0011}) begin
        errors++; $display("FAIL write_fwd_c%0d: got v=%b a=%h d=%h s=%b want v=1 a=10002004 d=a5a5a5a5 s=0011",
                           c, s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o);
      end
      checks++;
      if ({m_ready_o[0], m_rdata_o[0]} !== 33'h0) begin
        errors++; $display("FAIL write_m0_quiet_c%0d: got rdy=%b rd=%h want 0/0",
                           c, m_ready_o[0], m_rdata_o[0]);
      end
      checks++;
      if (m_ready_o[1] !== (c == 4)) begin
        errors++; $display("FAIL write_m1_ready_c%0d: got %b want %b", c, m_ready_o[1], (c == 4));
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_fairness();
    logic [N-1:0] prev_gnt;
    logic [N-1:0] cur_gnt;
    logic         found;
    apply_reset();
    request(0, 32'h0000_0100, 32'h0, 4'b0000);
    request(1, 32'h0000_0200, 32'h0, 4'b0000);
    prev_gnt = '0;
    for (int t = 0; t < 8; t++) begin
      found = 1'b0;
      for (int w = 0; w < 4 && !found; w++) begin
        @(negedge clk);
        if (grant_o !== '0) found = 1'b1;
        else step();
      end
      cur_gnt = grant_o;
      checks++;
      if (!found) begin
        errors++; $display("FAIL fair_no_grant_t%0d: got gnt=%b want a grant within 4 cycles", t, cur_gnt);
      end
      checks++;
      if (cur_gnt !== ((t % 2 == 0) ? 3'b001 : 3'b010)) begin
        errors++; $display("FAIL fair_order_t%0d: got %b want %b", t, cur_gnt,
                           (t % 2 == 0) ? 3'b001 : 3'b010);
      end
      checks++;
      if (cur_gnt === prev_gnt) begin
        errors++; $display("FAIL fair_repeat_t%0d: got %b twice want alternation", t, cur_gnt);
      end
      prev_gnt = cur_gnt;
      step();
      step();
      s_ready_i = 1'b1;
      @(negedge clk);
      checks++;
      if (m_ready_o !== cur_gnt) begin
        errors++; $display("FAIL fair_ready_t%0d: got %b want %b", t, m_ready_o, cur_gnt);
      end
      step();
      s_ready_i = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int tcount;
    apply_reset();
    tcount = 0;
    request(0, 32'h1000_3000, 32'h0, 4'b0000);
    step();
    for (int c = 1; c <= TO + 1; c++) begin
      @(negedge clk);
      if (timeout_o === 1'b1) tcount++;
      if (c <= TO) begin
        checks++;
        if ({s_valid_o, m_ready_o} !== 4'b1000) begin
          errors++; $display("FAIL tmo_wait_c%0d: got v=%b rdy=%b want v=1 rdy=000",
                             c, s_valid_o, m_ready_o);
        end
      end else begin
        checks++;
        if ({s_valid_o, m_ready_o, m_rdata_o[0], timeout_o} !== {1'b0, 3'b001, ERR, 1'b1}) begin
          errors++; $display("FAIL tmo_fire: got v=%b rdy=%b rd=%h to=%b want v=0 rdy=001 rd=deadbeef to=1",
                             s_valid_o, m_ready_o, m_rdata_o[0], timeout_o);
        end
      end
      step();
    end
    m_valid_i[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (timeout_o === 1'b1) tcount++;
      step();
    end
    checks++;
    if (tcount != 1) begin
      errors++; $display("FAIL tmo_pulse_count: got %0d want 1", tcount);
    end
    request(1, 32'h1000_3004, 32'h0, 4'b0000);
    step();
    s_ready_i = 1'b1;
    s_rdata_i = 32'h600D_CAFE;
    @(negedge clk);
    checks++;
    if ({m_ready_o, m_rdata_o[1], timeout_o} !== {3'b010, 32'h600D_CAFE, 1'b0}) begin
      errors++; $display("FAIL tmo_next_m1: got rdy=%b rd=%h to=%b want rdy=010 rd=600dcafe to=0",
                         m_ready_o, m_rdata_o[1], timeout_o);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_ready_timeout_race();
    apply_reset();
    request(0, 32'h1000_4000, 32'h0, 4'b0000);
    step();
    for (int c = 1; c <= TO + 1; c++) begin
      if (c == TO + 1) begin
        s_ready_i = 1'b1;
        s_rdata_i = 32'h7777_1234;
      end
      @(negedge clk);
      if (c == TO + 1) begin
        checks++;
        if ({s_valid_o, m_ready_o, m_rdata_o[0], timeout_o} !== {1'b1, 3'b001, 32'h7777_1234, 1'b0}) begin
          errors++; $display("FAIL race: got v=%b rdy=%b rd=%h to=%b want v=1 rdy=001 rd=77771234 to=0",
                             s_valid_o, m_ready_o, m_rdata_o[0], timeout_o);
        end
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    request(0, 32'h1000_5000, 32'h0, 4'b0000);
    step();
    step();
    @(negedge clk);
    checks++;
    if ({grant_o, s_valid_o} !== {3'b001, 1'b1}) begin
      errors++; $display("FAIL rstmid_pre: got gnt=%b v=%b want gnt=001 v=1", grant_o, s_valid_o);
    end
    step();
    rst_n_i = 1'b0;
    step();
    rst_n_i      = 1'b1;
    m_valid_i[0] = 1'b0;
    request(1, 32'h1000_5004, 32'h0, 4'b0000);
    @(negedge clk);
    checks++;
    if ({s_valid_o, m_ready_o, m_rdata_o, grant_o, timeout_o} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got v=%b rdy=%b rd=%h gnt=%b to=%b want all 0",
                         s_valid_o, m_ready_o, m_rdata_o, grant_o, timeout_o);
    end
    step();
    @(negedge clk);
    checks++;
    if ({grant_o, s_valid_o, s_addr_o} !== {3'b010, 1'b1, 32'h1000_5004}) begin
      errors++; $display("FAIL rstmid_regrant: got gnt=%b v=%b a=%h want gnt=010 v=1 a=10005004",
                         grant_o, s_valid_o, s_addr_o);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_random();
    logic               mb;
    int                 owner, age, ptr, pk;
    logic [N-1:0]       done_prev;
    logic               slow;
    logic               e_sv, e_to, e_done;
    logic [N-1:0]       e_mr, e_gr;
    logic [N-1:0][31:0] e_rd;
    apply_reset();
    mb = 1'b0; owner = 0; age = 0; ptr = 0; done_prev = '0; slow = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      // Masters obey the hold-until-ready rule.
      for (int i = 0; i < N; i++) begin
        if (m_valid_i[i]) begin
          if (done_prev[i]) begin
            if ($urandom_range(0, 1) == 1)
              request(i, $urandom, $urandom, 4'($urandom_range(0, 15)));
            else
              m_valid_i[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          request(i, $urandom, $urandom, 4'($urandom_range(0, 15)));
        end
      end
      if (cyc % 100 == 0) slow = 1'($urandom_range(0, 1));
      s_ready_i = slow ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      s_rdata_i = $urandom;
      @(negedge clk);

      e_sv = 1'b0; e_to = 1'b0; e_done = 1'b0;
      e_mr = '0; e_gr = '0; e_rd = '0; done_prev = '0;
      if (mb) begin
        e_to        = !s_ready_i && (age == TO + 1);
        e_done      = s_ready_i || e_to;
        e_gr[owner] = 1'b1;
        e_sv        = m_valid_i[owner] && !e_to;
        if (e_done) begin
          e_mr[owner] = 1'b1;
          e_rd[owner] = s_ready_i ? s_rdata_i : ERR;
        end
        checks++;
        if ({s_addr_o, s_wdata_o, s_wstrb_o} !== {m_addr_i[owner], m_wdata_i[owner], m_wstrb_i[owner]}) begin
          errors++; $display("FAIL rnd_payload_cyc%0d: got a=%h d=%h s=%b want a=%h d=%h s=%b", cyc,
                             s_addr_o, s_wdata_o, s_wstrb_o, m_addr_i[owner], m_wdata_i[owner], m_wstrb_i[owner]);
        end
      end
      checks++;
      if ({s_valid_o, m_ready_o, m_rdata_o, grant_o, timeout_o} !== {e_sv, e_mr, e_rd, e_gr, e_to}) begin
        errors++; $display("FAIL rnd_ctl_cyc%0d: got v=%b rdy=%b rd=%h gnt=%b to=%b want v=%b rdy=%b rd=%h gnt=%b to=%b",
                           cyc, s_valid_o, m_ready_o, m_rdata_o, grant_o, timeout_o,
                           e_sv, e_mr, e_rd, e_gr, e_to);
      end

      // Advance the model to the state after the coming edge.
      if (mb) begin
        if (e_done) begin
          done_prev[owner] = 1'b1;
          ptr = (owner + 1) % N;
          mb  = 1'b0;
        end else begin
          age++;
        end
      end else begin
        pk = model_pick(m_valid_i, ptr);
        if (pk >= 0) begin
          mb    = 1'b1;
          owner = pk;
          age   = 1;
        end
      end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    rst_n_i = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_write_forwarding();
    test_fairness();
    test_timeout();
    test_ready_timeout_race();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
